// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchronizer followed by a stability-qualifying
// FSM. The clean level "out" only follows the raw input once the synchronized
// value has differed from out for STABLE_CYCLES consecutive clock samples.
// rise_pulse / fall_pulse mark the single cycle in which out first shows its
// new level; busy is high while a candidate level change is being qualified.
// Every output comes straight from a flop, so none of them can glitch.
module input_debouncer #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_raw,
   output logic out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   // Qualification FSM encoding. Bit 1 is the level currently shown on out,
   // bit 0 is set while a change towards the opposite level is being counted.
   localparam logic [1:0] IDLE_LOW  = 2'd0;
   localparam logic [1:0] QUAL_HIGH = 2'd1;
   localparam logic [1:0] IDLE_HIGH = 2'd2;
   localparam logic [1:0] QUAL_LOW  = 2'd3;

   // The count reached in the sample just before the one that qualifies.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             out_q,   out_d;
   logic             rise_q,  rise_d;
   logic             fall_q,  fall_d;
   logic             busy_q,  busy_d;

   // Synchronizer chain: in_raw has no timing relation to clk, so the FSM
   // only ever looks at the second stage.
   always_comb begin
      sync1_d = in_raw;
      sync2_d = sync1_q;
   end

   // Next-state logic. A sample equal to out always drops back to idle with
   // the counter cleared, so a single matching sample restarts qualification.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (sync2_q) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = IDLE_HIGH;
                  out_d   = 1'b1;
                  rise_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = QUAL_HIGH;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         QUAL_HIGH: begin
            if (!sync2_q) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HIGH;
               out_d   = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!sync2_q) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = IDLE_LOW;
                  out_d   = 1'b0;
                  fall_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = QUAL_LOW;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         QUAL_LOW: begin
            if (sync2_q) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
               out_d   = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
            out_d   = 1'b0;
         end
      endcase
      busy_d = (state_d == QUAL_HIGH) || (state_d == QUAL_LOW);
   end

   // State register; rst_n low clears everything at once, without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign out        = out_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer. Two instances (STABLE_CYCLES=4 and 1) share one
// stimulus stream. A reference model, written in terms of "how many
// consecutive synchronized samples disagree with the output", pushes the
// expected {out, rise_pulse, fall_pulse, busy} after every clock edge; a
// monitor pops and compares 2 ns after each edge.
module tb_input_debouncer;

   localparam int W = 4;
   localparam int S0 = 4;
   localparam int S1 = 1;

   logic clk;
   logic rst_n;
   logic in_raw;
   logic out0, rise0, fall0, busy0;
   logic out1, rise1, fall1, busy1;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];

   // model state, index 0 -> S0 instance, index 1 -> S1 instance
   logic m_pipe_a[2];
   logic m_pipe_b[2];
   logic m_out[2];
   logic m_rise[2];
   logic m_fall[2];
   int   m_run[2];

   input_debouncer #(.STABLE_CYCLES(S0), .CNT_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_raw(in_raw),
      .out(out0), .rise_pulse(rise0), .fall_pulse(fall0), .busy(busy0)
   );

   input_debouncer #(.STABLE_CYCLES(S1), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_raw(in_raw),
      .out(out1), .rise_pulse(rise1), .fall_pulse(fall1), .busy(busy1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear(input int i);
      m_pipe_a[i] = 1'b0;
      m_pipe_b[i] = 1'b0;
      m_out[i]    = 1'b0;
      m_rise[i]   = 1'b0;
      m_fall[i]   = 1'b0;
      m_run[i]    = 0;
   endtask

   // One clock edge of the reference: the level seen is in_raw from two edges
   // earlier; out flips once S consecutive seen levels disagree with it.
   task automatic model_step(input int i, input int s_cyc);
      logic seen;
      seen        = m_pipe_b[i];
      m_pipe_b[i] = m_pipe_a[i];
      m_pipe_a[i] = in_raw;
      m_rise[i]   = 1'b0;
      m_fall[i]   = 1'b0;
      if (seen != m_out[i]) begin
         m_run[i] = m_run[i] + 1;
         if (m_run[i] >= s_cyc) begin
            m_out[i] = seen;
            m_run[i] = 0;
            if (seen) m_rise[i] = 1'b1;
            else      m_fall[i] = 1'b1;
         end
      end else begin
         m_run[i] = 0;
      end
   endtask

   function automatic logic [W-1:0] model_vec(input int i);
      return {m_out[i], m_rise[i], m_fall[i], (m_run[i] != 0)};
   endfunction

   // reference model: advance on every edge and queue the expected outputs
   always @(posedge clk) begin
      if (!rst_n) begin
         model_clear(0);
         model_clear(1);
      end else begin
         model_step(0, S0);
         model_step(1, S1);
      end
      exp_q0.push_back(model_vec(0));
      exp_q1.push_back(model_vec(1));
   end

   // asynchronous reset discards model state immediately
   always @(negedge rst_n) begin
      model_clear(0);
      model_clear(1);
   end

   task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s at %0t: got {out,rise,fall,busy}=%b expected %b", name, $time, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(posedge clk) begin
      #2;
      if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL queue_empty at %0t: got no expected entry, required one per edge", $time);
      end else begin
         compare("dut_s4", {out0, rise0, fall0, busy0}, exp_q0.pop_front());
         compare("dut_s1", {out1, rise1, fall1, busy1}, exp_q1.pop_front());
      end
      if (rise0 && fall0) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL both_pulses at %0t: got rise=1 fall=1 required at most one", $time);
      end
   end

   // driver tasks (called on a falling edge)
   task automatic hold(input logic val, input int n);
      in_raw = val;
      repeat (n) @(negedge clk);
   endtask

   // assert reset 3 ns after the next rising edge and check outputs clear
   // before any further clock edge
   task automatic async_reset_check(input string name);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      compare({name, "_s4"}, {out0, rise0, fall0, busy0}, 4'b0000);
      compare({name, "_s1"}, {out1, rise1, fall1, busy1}, 4'b0000);
      @(negedge clk);
   endtask

   initial begin
      in_raw = 1'b1;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);          // reset held with in_raw=1
      in_raw = 1'b0;
      rst_n  = 1'b1;
      hold(1'b0, 4);
      // clean rise, then clean fall
      hold(1'b1, 10);
      hold(1'b0, 10);
      // glitch: high for 3 cycles only
      hold(1'b1, 3);
      hold(1'b0, 10);
      // chatter then settle high
      hold(1'b1, 1);
      hold(1'b0, 1);
      hold(1'b1, 1);
      hold(1'b0, 1);
      hold(1'b1, 12);
      hold(1'b0, 10);
      // reset in the middle of a rise qualification (edge 4)
      in_raw = 1'b1;
      repeat (3) @(posedge clk);
      async_reset_check("reset_mid_qual");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold(1'b1, 12);
      hold(1'b0, 10);
      // randomized segments
      for (int k = 0; k < 60; k++) begin
         hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
         if (k == 30) begin
            async_reset_check("reset_random");
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      hold(1'b0, 10);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
